// File: rtl/grey_frame_reader_pkg.sv
// Shared camera constants and reader FSM encoding, common to the greyscale packer and the frame reader.
package grey_frame_reader_pkg;

  localparam int CAM_H_PIXELS     = 320;
  localparam int CAM_V_PIXELS     = 240;
  localparam int CAM_PIX_PER_WORD = 6;
  localparam int CAM_WORD_WIDTH   = 48;
  localparam int CAM_PIX_WIDTH    = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PRIME  = 2'd1,
    ST_STREAM = 2'd2
  } frame_state_t;

  function automatic int cam_num_words(input int h_pixels, input int v_pixels, input int pix_per_word);
    return (h_pixels * v_pixels) / pix_per_word;
  endfunction

endpackage

// File: rtl/grey_frame_reader_pipeline.sv
// Fixed-depth register delay line; here it turns the BRAM read enable into a read-data-valid strobe.
module grey_frame_reader_pipeline #(
  parameter int DEPTH      = 2,
  parameter int DATA_WIDTH = 1
) (
  input  logic                  clk_pixel,
  input  logic                  rst_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out
);

  logic [DATA_WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk_pixel or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= data_in;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign data_out = stage[DEPTH-1];

endmodule

// File: rtl/grey_frame_reader.sv
// Streams one greyscale frame out of packed 48-bit BRAM words with a valid/ready pixel handshake.
//   state     | meaning
//   ST_IDLE   | waiting for start_in, no reads issued
//   ST_PRIME  | word 0 read in flight
//   ST_STREAM | emitting pixels; next word prefetched into the holding register
module grey_frame_reader
  import grey_frame_reader_pkg::*;
#(
  parameter int H_PIXELS     = CAM_H_PIXELS,
  parameter int V_PIXELS     = CAM_V_PIXELS,
  parameter int PIX_PER_WORD = CAM_PIX_PER_WORD,
  parameter int BRAM_LATENCY = 2
) (
  input  logic                      clk_pixel,
  input  logic                      rst_in,
  input  logic                      start_in,
  output logic                      busy_out,
  output logic [13:0]               bram_addr_out,
  output logic                      bram_en_out,
  input  logic [CAM_WORD_WIDTH-1:0] bram_data_in,
  output logic [7:0]                pixel_out,
  output logic [8:0]                hcount_out,
  output logic [7:0]                vcount_out,
  output logic                      pixel_valid_out,
  input  logic                      pixel_ready_in,
  output logic                      frame_done_out
);

  localparam int                   NUM_WORDS = cam_num_words(H_PIXELS, V_PIXELS, PIX_PER_WORD);
  localparam logic [13:0]          LAST_WORD = 14'(NUM_WORDS - 1);
  localparam logic [8:0]           H_LAST    = 9'(H_PIXELS - 1);
  localparam logic [7:0]           V_LAST    = 8'(V_PIXELS - 1);
  localparam int                   PIX_CNT_W = $clog2(PIX_PER_WORD);
  localparam logic [PIX_CNT_W-1:0] PIX_LAST  = PIX_CNT_W'(PIX_PER_WORD - 1);

  // The prefetch must land before the current word drains, and the frame must fill whole words.
  if (PIX_PER_WORD <= BRAM_LATENCY + 1) begin : g_bad_latency
    $error("grey_frame_reader: PIX_PER_WORD must exceed BRAM_LATENCY+1");
  end
  if (((H_PIXELS * V_PIXELS) % PIX_PER_WORD) != 0) begin : g_bad_packing
    $error("grey_frame_reader: H_PIXELS*V_PIXELS must be a multiple of PIX_PER_WORD");
  end

  frame_state_t state, state_nxt;

  logic                      rd_valid;
  logic                      handshake;
  logic                      last_in_word;
  logic                      last_in_frame;
  logic                      issue_first;
  logic                      issue_next;
  logic                      load_first;
  logic                      word_end;
  logic                      frame_end;
  logic                      load_word;
  logic [CAM_WORD_WIDTH-1:0] shift_word;
  logic [CAM_WORD_WIDTH-1:0] hold_word;
  logic [CAM_WORD_WIDTH-1:0] next_word;
  logic [PIX_CNT_W-1:0]      pix_left;

  grey_frame_reader_pipeline #(
    .DEPTH      (BRAM_LATENCY),
    .DATA_WIDTH (1)
  ) u_rd_valid (
    .clk_pixel (clk_pixel),
    .rst_in    (rst_in),
    .data_in   (bram_en_out),
    .data_out  (rd_valid)
  );

  assign handshake     = pixel_valid_out & pixel_ready_in;
  assign last_in_word  = (pix_left == '0);
  assign last_in_frame = (hcount_out == H_LAST) && (vcount_out == V_LAST);
  // Bypass covers a prefetch landing on the same edge the current word drains.
  assign next_word     = rd_valid ? bram_data_in : hold_word;
  assign pixel_out     = shift_word[CAM_WORD_WIDTH-1 -: CAM_PIX_WIDTH];

  always_ff @(posedge clk_pixel or posedge rst_in) begin
    if (rst_in) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:   if (start_in)                     state_nxt = ST_PRIME;
      ST_PRIME:  if (rd_valid)                     state_nxt = ST_STREAM;
      ST_STREAM: if (handshake && last_in_frame)   state_nxt = ST_IDLE;
      default:                                     state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    issue_first = 1'b0;
    load_first  = 1'b0;
    word_end    = 1'b0;
    frame_end   = 1'b0;
    busy_out    = 1'b0;
    case (state)
      ST_IDLE:   issue_first = start_in;
      ST_PRIME: begin
        busy_out   = 1'b1;
        load_first = rd_valid;
      end
      ST_STREAM: begin
        busy_out  = 1'b1;
        frame_end = handshake && last_in_frame;
        word_end  = handshake && last_in_word && !last_in_frame;
      end
      default: ;
    endcase
    load_word  = load_first | word_end;
    issue_next = load_word && (bram_addr_out != LAST_WORD);
  end

  always_ff @(posedge clk_pixel or posedge rst_in) begin
    if (rst_in) begin
      bram_en_out     <= 1'b0;
      bram_addr_out   <= '0;
      hold_word       <= '0;
      shift_word      <= '0;
      pix_left        <= '0;
      pixel_valid_out <= 1'b0;
      hcount_out      <= '0;
      vcount_out      <= '0;
      frame_done_out  <= 1'b0;
    end else begin
      bram_en_out <= issue_first | issue_next;
      if (issue_first)     bram_addr_out <= '0;
      else if (issue_next) bram_addr_out <= bram_addr_out + 14'd1;

      if ((state == ST_STREAM) && rd_valid) hold_word <= bram_data_in;

      if (load_first)     shift_word <= bram_data_in;
      else if (word_end)  shift_word <= next_word;
      else if (frame_end) shift_word <= '0;
      else if (handshake) shift_word <= shift_word << CAM_PIX_WIDTH;

      if (load_word)                      pix_left <= PIX_LAST;
      else if (handshake && !last_in_word) pix_left <= pix_left - 1'b1;

      if (load_first)     pixel_valid_out <= 1'b1;
      else if (frame_end) pixel_valid_out <= 1'b0;

      if (issue_first) begin
        hcount_out <= '0;
        vcount_out <= '0;
      end else if (handshake) begin
        if (hcount_out == H_LAST) begin
          hcount_out <= '0;
          vcount_out <= last_in_frame ? '0 : vcount_out + 8'd1;
        end else begin
          hcount_out <= hcount_out + 9'd1;
        end
      end

      frame_done_out <= frame_end;
    end
  end

endmodule

// File: tb/tb_grey_frame_reader.sv
// Randomized self-checking bench: BRAM model plus a raster-order reference of the pixel stream.
module tb_grey_frame_reader;

  localparam int H   = 60;
  localparam int V   = 20;
  localparam int PPW = 6;
  localparam int N   = H * V;
  localparam int NW  = N / PPW;

  logic        clk_pixel = 1'b0;
  logic        rst_in = 1'b1;
  logic        start_in = 1'b0;
  logic        pixel_ready_in = 1'b0;
  logic        busy_out, bram_en_out, pixel_valid_out, frame_done_out;
  logic [13:0] bram_addr_out;
  logic [47:0] bram_data_in = '0;
  logic [47:0] bram_q1 = '0;
  logic [7:0]  pixel_out;
  logic [8:0]  hcount_out;
  logic [7:0]  vcount_out;

  logic [47:0] mem [NW];
  logic [7:0]  cap_pix [6];
  logic [8:0]  cap_h [6];
  logic [7:0]  cap_v [6];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rd_count = 0, rd_next = 0, rd_order_err = 0, rd_oob = 0, en_idle = 0;

  always #5 clk_pixel = ~clk_pixel;

  grey_frame_reader #(
    .H_PIXELS     (H),
    .V_PIXELS     (V),
    .PIX_PER_WORD (PPW),
    .BRAM_LATENCY (2)
  ) dut (
    .clk_pixel       (clk_pixel),
    .rst_in          (rst_in),
    .start_in        (start_in),
    .busy_out        (busy_out),
    .bram_addr_out   (bram_addr_out),
    .bram_en_out     (bram_en_out),
    .bram_data_in    (bram_data_in),
    .pixel_out       (pixel_out),
    .hcount_out      (hcount_out),
    .vcount_out      (vcount_out),
    .pixel_valid_out (pixel_valid_out),
    .pixel_ready_in  (pixel_ready_in),
    .frame_done_out  (frame_done_out)
  );

  // Two-cycle read latency BRAM; unrequested cycles return a poison pattern.
  always @(posedge clk_pixel) begin
    bram_q1      <= (bram_en_out && int'(bram_addr_out) < NW) ? mem[bram_addr_out] : 48'hBAD0BAD0BAD0;
    bram_data_in <= bram_q1;
  end

  // Read monitor: reads of a frame must be addresses 0,1,2,... each exactly once.
  always @(posedge clk_pixel) begin
    cyc <= cyc + 1;
    if (start_in && !busy_out && !rst_in) begin
      rd_count <= 0; rd_next <= 0; rd_order_err <= 0; rd_oob <= 0;
    end else if (bram_en_out) begin
      rd_count <= rd_count + 1;
      rd_next  <= rd_next + 1;
      if (bram_addr_out != 14'(rd_next)) rd_order_err <= rd_order_err + 1;
      if (int'(bram_addr_out) >= NW) rd_oob <= rd_oob + 1;
    end
    if (bram_en_out && !busy_out) en_idle <= en_idle + 1;
  end

  function automatic logic [7:0] model_pixel(input int p);
    int w, k;
    w = p / PPW;
    k = p % PPW;
    return 8'((mem[w] >> (40 - 8 * k)) & 48'hFF);
  endfunction

  task automatic fill_mem();
    for (int i = 0; i < NW; i++) mem[i] = 48'({$urandom, $urandom});
  endtask

  // mode 0: ready=1, 1: random ready, 2: 4-cycle stall on pixel 5, 3: ready=1 with start pulsed at pixel 100
  task automatic drive_frame(input int mode, output int n_hs, output int first_hs, output int last_hs,
                             output int done_rel, output int pix_err, output int stall_err, output int busy_err);
    int s_edge, p, stall_left;
    bit done, pulsed, r, prev_hold;
    logic [7:0] pv_pix;
    logic [8:0] pv_h;
    logic [7:0] pv_v;
    n_hs = 0; first_hs = -1; last_hs = -1; done_rel = -1;
    pix_err = 0; stall_err = 0; busy_err = 0;
    p = 0; stall_left = 4; done = 0; pulsed = 0; prev_hold = 0;
    pv_pix = '0; pv_h = '0; pv_v = '0;
    for (int i = 0; i < 6; i++) begin cap_pix[i] = 'x; cap_h[i] = 'x; cap_v[i] = 'x; end
    start_in = 1'b1;
    s_edge = cyc + 1;
    @(negedge clk_pixel);
    start_in = 1'b0;
    for (int c = 0; c < 8 * N + 200 && !done; c++) begin
      if (prev_hold && (pixel_out !== pv_pix || hcount_out !== pv_h || vcount_out !== pv_v
                        || pixel_valid_out !== 1'b1)) stall_err++;
      if (frame_done_out === 1'b1) begin
        done = 1;
        done_rel = cyc + 1 - s_edge;
        if (busy_out !== 1'b0) busy_err++;
      end else if (busy_out !== 1'b1) busy_err++;
      if (mode == 3 && p == 100 && !pulsed) begin start_in = 1'b1; pulsed = 1; end
      else start_in = 1'b0;
      case (mode)
        1: r = 1'($urandom_range(0, 1));
        2: begin
          r = !(p == 5 && stall_left > 0);
          if (!r && pixel_valid_out) stall_left--;
        end
        default: r = 1'b1;
      endcase
      pixel_ready_in = r;
      if (pixel_valid_out === 1'b1 && r) begin
        if (p >= N) pix_err++;
        else if (pixel_out !== model_pixel(p) || hcount_out !== 9'(p % H) || vcount_out !== 8'(p / H))
          pix_err++;
        if (p < 6) begin cap_pix[p] = pixel_out; cap_h[p] = hcount_out; cap_v[p] = vcount_out; end
        if (n_hs == 0) first_hs = cyc + 1 - s_edge;
        last_hs = cyc + 1 - s_edge;
        n_hs++;
        p++;
      end
      prev_hold = (pixel_valid_out === 1'b1) && !r;
      pv_pix = pixel_out; pv_h = hcount_out; pv_v = vcount_out;
      if (!done) @(negedge clk_pixel);
    end
    pixel_ready_in = 1'b0;
    start_in = 1'b0;
    @(negedge clk_pixel);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk_pixel);
    checks++;
    if ({busy_out, bram_en_out, pixel_valid_out, frame_done_out, bram_addr_out, pixel_out, hcount_out, vcount_out} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b en=%b valid=%b done=%b addr=%0d pix=%0h h=%0d v=%0d, required all 0",
               busy_out, bram_en_out, pixel_valid_out, frame_done_out, bram_addr_out, pixel_out, hcount_out, vcount_out);
    end
    rst_in = 1'b0;
    repeat (3) @(negedge clk_pixel);
    checks++;
    if (busy_out !== 1'b0 || bram_en_out !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got busy=%b en=%b, required 0 0", busy_out, bram_en_out);
    end
  endtask

  task automatic test_first_word();
    int n, f, l, d, pe, se, be;
    fill_mem();
    mem[0] = 48'h010203040506;
    drive_frame(0, n, f, l, d, pe, se, be);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (cap_pix[i] !== 8'(i + 1) || cap_h[i] !== 9'(i) || cap_v[i] !== 8'd0) begin
        errors++;
        $display("FAIL first_word_pixel%0d: got pix=%0h h=%0d v=%0d, required pix=%0h h=%0d v=0",
                 i, cap_pix[i], cap_h[i], cap_v[i], i + 1, i);
      end
    end
    checks++;
    if (pe !== 0) begin errors++; $display("FAIL first_word_stream: got %0d pixel errors, required 0", pe); end
  endtask

  task automatic test_full_frame();
    int n, f, l, d, pe, se, be;
    fill_mem();
    drive_frame(0, n, f, l, d, pe, se, be);
    checks++; if (n !== N) begin errors++; $display("FAIL full_handshakes: got %0d, required %0d", n, N); end
    checks++; if (f !== 4) begin errors++; $display("FAIL full_first_latency: got %0d, required 4", f); end
    checks++; if (l !== N + 3) begin errors++; $display("FAIL full_last_handshake: got %0d, required %0d", l, N + 3); end
    checks++; if (d !== N + 4) begin errors++; $display("FAIL full_done_time: got %0d, required %0d", d, N + 4); end
    checks++; if (pe !== 0) begin errors++; $display("FAIL full_pixels: got %0d errors, required 0", pe); end
    checks++; if (be !== 0) begin errors++; $display("FAIL full_busy: got %0d errors, required 0", be); end
    checks++; if (rd_count !== NW) begin errors++; $display("FAIL full_reads: got %0d, required %0d", rd_count, NW); end
    checks++;
    if (rd_order_err !== 0 || rd_oob !== 0) begin
      errors++; $display("FAIL full_read_order: got order_err=%0d oob=%0d, required 0 0", rd_order_err, rd_oob);
    end
  endtask

  task automatic test_random_ready();
    int n, f, l, d, pe, se, be;
    fill_mem();
    drive_frame(1, n, f, l, d, pe, se, be);
    checks++; if (n !== N) begin errors++; $display("FAIL rand_handshakes: got %0d, required %0d", n, N); end
    checks++; if (pe !== 0) begin errors++; $display("FAIL rand_pixels: got %0d errors, required 0", pe); end
    checks++; if (se !== 0) begin errors++; $display("FAIL rand_stall_stable: got %0d changes, required 0", se); end
    checks++; if (d < N + 4) begin errors++; $display("FAIL rand_done: got %0d, required >= %0d", d, N + 4); end
    checks++;
    if (rd_count !== NW || rd_order_err !== 0) begin
      errors++; $display("FAIL rand_reads: got count=%0d order_err=%0d, required %0d 0", rd_count, rd_order_err, NW);
    end
  endtask

  task automatic test_start_mid_frame();
    int n, f, l, d, pe, se, be;
    fill_mem();
    drive_frame(3, n, f, l, d, pe, se, be);
    checks++; if (n !== N || pe !== 0) begin errors++; $display("FAIL midstart_pixels: got n=%0d err=%0d, required %0d 0", n, pe, N); end
    checks++; if (d !== N + 4) begin errors++; $display("FAIL midstart_done: got %0d, required %0d", d, N + 4); end
    checks++;
    if (rd_count !== NW || rd_order_err !== 0) begin
      errors++; $display("FAIL midstart_reads: got count=%0d order_err=%0d, required %0d 0", rd_count, rd_order_err, NW);
    end
  endtask

  task automatic test_reset_mid_frame();
    int n, f, l, d, pe, se, be, cnt;
    fill_mem();
    start_in = 1'b1;
    @(negedge clk_pixel);
    start_in = 1'b0;
    pixel_ready_in = 1'b1;
    cnt = 0;
    for (int c = 0; c < 4 * N && cnt < 1000; c++) begin
      if (pixel_valid_out === 1'b1) cnt++;
      @(negedge clk_pixel);
    end
    checks++; if (cnt !== 1000) begin errors++; $display("FAIL rstmid_reach: got %0d handshakes, required 1000", cnt); end
    rst_in = 1'b1;
    pixel_ready_in = 1'b0;
    #1;
    checks++;
    if ({busy_out, bram_en_out, pixel_valid_out, frame_done_out, bram_addr_out, pixel_out, hcount_out, vcount_out} !== '0) begin
      errors++; $display("FAIL rstmid_async: got busy=%b en=%b valid=%b addr=%0d h=%0d, required all 0",
                         busy_out, bram_en_out, pixel_valid_out, bram_addr_out, hcount_out);
    end
    @(negedge clk_pixel);
    checks++;
    if ({busy_out, bram_en_out, pixel_valid_out, frame_done_out, bram_addr_out, pixel_out, hcount_out, vcount_out} !== '0) begin
      errors++; $display("FAIL rstmid_next_edge: got busy=%b en=%b valid=%b addr=%0d h=%0d, required all 0",
                         busy_out, bram_en_out, pixel_valid_out, bram_addr_out, hcount_out);
    end
    rst_in = 1'b0;
    @(negedge clk_pixel);
    drive_frame(0, n, f, l, d, pe, se, be);
    checks++; if (cap_pix[0] !== model_pixel(0)) begin errors++; $display("FAIL rstmid_pixel0: got %0h, required %0h", cap_pix[0], model_pixel(0)); end
    checks++; if (f !== 4) begin errors++; $display("FAIL rstmid_latency: got %0d, required 4", f); end
    checks++; if (n !== N || pe !== 0) begin errors++; $display("FAIL rstmid_frame: got n=%0d err=%0d, required %0d 0", n, pe, N); end
  endtask

  task automatic test_word_boundary_stall();
    int n, f, l, d, pe, se, be;
    fill_mem();
    drive_frame(2, n, f, l, d, pe, se, be);
    checks++; if (n !== N || pe !== 0) begin errors++; $display("FAIL boundary_pixels: got n=%0d err=%0d, required %0d 0", n, pe, N); end
    checks++; if (se !== 0) begin errors++; $display("FAIL boundary_stable: got %0d changes, required 0", se); end
    checks++; if (d !== N + 8) begin errors++; $display("FAIL boundary_done: got %0d, required %0d", d, N + 8); end
    checks++;
    if (rd_count !== NW || rd_order_err !== 0) begin
      errors++; $display("FAIL boundary_reads: got count=%0d order_err=%0d, required %0d 0", rd_count, rd_order_err, NW);
    end
  endtask

  task automatic test_idle_enable();
    checks++;
    if (en_idle !== 0) begin errors++; $display("FAIL idle_enable: got %0d reads while idle, required 0", en_idle); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_first_word();
    test_full_frame();
    test_random_ready();
    test_start_mid_frame();
    test_reset_mid_frame();
    test_word_boundary_stall();
    test_idle_enable();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
